// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator and state encodings shared by the grid calculator entry logic.
package calc_pkg;
    localparam logic [4:0] K_DIGIT_LAST = 5'h0F;
    localparam logic [4:0] K_ADD        = 5'h10;
    localparam logic [4:0] K_MUL        = 5'h11;
    localparam logic [4:0] K_AND        = 5'h12;
    localparam logic [4:0] K_EXE        = 5'h13;
    localparam logic [4:0] K_SUB        = 5'h14;
    localparam logic [4:0] K_OR         = 5'h15;
    localparam logic [4:0] K_CE         = 5'h16;
    localparam logic [4:0] K_CLR        = 5'h17;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_MUL = 3'd1,
        OP_AND = 3'd2,
        OP_SUB = 3'd4,
        OP_OR  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_WAIT = 2'd2,
        S_RES  = 2'd3
    } state_e;

    function automatic logic is_digit(input logic [4:0] v);
        return v <= K_DIGIT_LAST;
    endfunction

    function automatic logic is_op(input logic [4:0] v);
        return v == K_ADD || v == K_MUL || v == K_AND || v == K_SUB || v == K_OR;
    endfunction
endpackage

// File: rtl/digit_accum.sv
// digit_accum: one operand register with its digit count; hex or decimal digit shift-in.
module digit_accum #(
    parameter int W        = 16,
    parameter int N_DIGITS = 4,
    parameter int CW       = $clog2(N_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          dig_i,
    input  logic [3:0]    d_i,
    input  logic          dec_mode_i,
    input  logic          load_i,
    input  logic [W-1:0]  load_val_i,
    input  logic [CW-1:0] load_cnt_i,
    output logic [W-1:0]  value_o,
    output logic [CW-1:0] cnt_o
);
    logic [W-1:0]  val_q, val_d, acc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    assign accept  = dig_i && cnt_q < CW'(N_DIGITS) && !(dec_mode_i && d_i > 4'd9);
    // x*10 as two shifts so the product truncates to W bits naturally
    assign acc     = dec_mode_i ? (val_q << 3) + (val_q << 1) + W'(d_i) : (val_q << 4) | W'(d_i);
    assign value_o = val_q;
    assign cnt_o   = cnt_q;

    always_comb begin
        val_d = clr_i ? '0 : load_i ? load_val_i : accept ? acc : val_q;
        cnt_d = clr_i ? '0 : load_i ? load_cnt_i : accept ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: operand/operator entry sequencer with ALU valid/ready handoff.
// Define CALC_CHAIN_EN to let an operator in the result state chain the result into A.
module calc_entry_fsm import calc_pkg::*; #(
    parameter int W        = 16,
    parameter int N_DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [4:0]   val,
    input  logic         dec_mode,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [2:0]   op_code,
    output logic         exe_valid,
    input  logic         exe_ready,
    input  logic         res_valid,
    input  logic [W-1:0] result,
    output logic [W-1:0] disp_value,
    output logic [1:0]   state
);
    localparam int CW = $clog2(N_DIGITS + 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic          ev_q, ev_d, hs_q, hs_d;
    logic [W-1:0]  res_q, res_d;
    logic          a_clr, a_dig, a_load, b_clr, b_dig;
    logic [W-1:0]  a_load_val, a_val, b_val;
    logic [CW-1:0] a_load_cnt, a_cnt, b_cnt;
    logic          k_dig, k_op, k_exe, k_ce, k_clr;

    assign k_dig = key_valid && is_digit(val);
    assign k_op  = key_valid && is_op(val);
    assign k_exe = key_valid && val == K_EXE;
    assign k_ce  = key_valid && val == K_CE;
    assign k_clr = key_valid && val == K_CLR;

    digit_accum #(.W(W), .N_DIGITS(N_DIGITS), .CW(CW)) u_acc_a (
        .clk(clk), .rst(rst), .clr_i(a_clr), .dig_i(a_dig), .d_i(val[3:0]),
        .dec_mode_i(dec_mode), .load_i(a_load), .load_val_i(a_load_val),
        .load_cnt_i(a_load_cnt), .value_o(a_val), .cnt_o(a_cnt)
    );

    digit_accum #(.W(W), .N_DIGITS(N_DIGITS), .CW(CW)) u_acc_b (
        .clk(clk), .rst(rst), .clr_i(b_clr), .dig_i(b_dig), .d_i(val[3:0]),
        .dec_mode_i(dec_mode), .load_i(1'b0), .load_val_i('0),
        .load_cnt_i('0), .value_o(b_val), .cnt_o(b_cnt)
    );

    assign op_a       = a_val;
    assign op_b       = b_val;
    assign op_code    = op_q;
    assign exe_valid  = ev_q;
    assign state      = state_q;
    assign disp_value = state_q == S_A ? a_val :
                        state_q == S_B ? (b_cnt == '0 ? a_val : b_val) :
                        state_q == S_WAIT ? b_val : res_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ev_d       = ev_q;
        hs_d       = hs_q;
        res_d      = res_q;
        a_clr      = 1'b0;
        a_dig      = 1'b0;
        a_load     = 1'b0;
        a_load_val = '0;
        a_load_cnt = '0;
        b_clr      = 1'b0;
        b_dig      = 1'b0;
        case (state_q)
            S_A: begin
                a_dig = k_dig;
                a_clr = k_ce;
                if (k_op) begin
                    op_d    = op_e'(val[2:0]);
                    b_clr   = 1'b1;
                    state_d = S_B;
                end
            end
            S_B: begin
                b_dig = k_dig;
                b_clr = k_ce;
                if (k_op && b_cnt == '0) op_d = op_e'(val[2:0]);
                if (k_exe && b_cnt != '0) begin
                    ev_d    = 1'b1;
                    hs_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ev_q && exe_ready) begin
                    ev_d = 1'b0;
                    hs_d = 1'b1;
                end
                // hs_q gates out any strobe that arrives before or with the transfer
                if (hs_q && res_valid) begin
                    res_d   = result;
                    state_d = S_RES;
                end
            end
            default: begin
                if (k_dig && !(dec_mode && val[3:0] > 4'd9)) begin
                    a_load     = 1'b1;
                    a_load_val = W'(val[3:0]);
                    a_load_cnt = CW'(1);
                    state_d    = S_A;
                end
`ifdef CALC_CHAIN_EN
                if (k_op) begin
                    a_load     = 1'b1;
                    a_load_val = res_q;
                    a_load_cnt = CW'(N_DIGITS);
                    op_d       = op_e'(val[2:0]);
                    b_clr      = 1'b1;
                    state_d    = S_B;
                end
`endif
                if (k_ce) begin
                    a_clr   = 1'b1;
                    state_d = S_A;
                end
            end
        endcase
        if (k_clr) begin
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            res_d   = '0;
            op_d    = OP_ADD;
            ev_d    = 1'b0;
            hs_d    = 1'b0;
            state_d = S_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            op_q    <= OP_ADD;
            ev_q    <= 1'b0;
            hs_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ev_q    <= ev_d;
            hs_q    <= hs_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb_calc_entry_fsm: vector table with expected outputs queued per step and checked one cycle later.
// Honours CALC_CHAIN_EN to pick the expected behaviour of an operator in the result state.
module tb_calc_entry_fsm;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, key_valid, dec_mode, exe_ready, res_valid, exe_valid;
    logic [4:0]  val;
    logic [15:0] op_a, op_b, result, disp_value;
    logic [2:0]  op_code;
    logic [1:0]  state;

    always #5 clk = ~clk;

    calc_entry_fsm #(.W(16), .N_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .val(val), .dec_mode(dec_mode),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .exe_valid(exe_valid),
        .exe_ready(exe_ready), .res_valid(res_valid), .result(result),
        .disp_value(disp_value), .state(state)
    );

    typedef struct {
        logic        kv;
        logic [4:0]  v;
        logic        dec, rdy, rv;
        logic [15:0] res;
        logic [1:0]  st;
        logic [15:0] a, b;
        logic [2:0]  op;
        logic [15:0] disp;
        logic        ev;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic kv, input logic [4:0] v, input logic dec, input logic rdy,
                                input logic rv, input logic [15:0] res, input logic [1:0] st,
                                input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                input logic [15:0] disp, input logic ev);
        vec_t x;
        x.kv = kv; x.v = v; x.dec = dec; x.rdy = rdy; x.rv = rv; x.res = res;
        x.st = st; x.a = a; x.b = b; x.op = op; x.disp = disp; x.ev = ev;
        return x;
    endfunction

    function automatic vec_t key(input logic [4:0] v, input logic dec, input logic [1:0] st,
                                 input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                 input logic [15:0] disp, input logic ev);
        return mk(1'b1, v, dec, 1'b0, 1'b0, 16'h0, st, a, b, op, disp, ev);
    endfunction

    function automatic vec_t idle(input logic rdy, input logic rv, input logic [15:0] res,
                                  input logic [1:0] st, input logic [15:0] a, input logic [15:0] b,
                                  input logic [2:0] op, input logic [15:0] disp, input logic ev);
        return mk(1'b0, 5'h1F, 1'b0, rdy, rv, res, st, a, b, op, disp, ev);
    endfunction

    task automatic chk(input string n, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic step(input int idx, input vec_t x);
        vec_t e;
        @(negedge clk);
        key_valid = x.kv; val = x.v; dec_mode = x.dec;
        exe_ready = x.rdy; res_valid = x.rv; result = x.res;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("step%0d state", idx), state, e.st);
        chk($sformatf("step%0d op_a", idx), op_a, e.a);
        chk($sformatf("step%0d op_b", idx), op_b, e.b);
        chk($sformatf("step%0d op_code", idx), op_code, e.op);
        chk($sformatf("step%0d disp", idx), disp_value, e.disp);
        chk($sformatf("step%0d exe_valid", idx), exe_valid, e.ev);
        key_valid = 1'b0; exe_ready = 1'b0; res_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // hex entry, fifth digit ignored, stray keys
        vecs.push_back(key(5'h1, 0, S_A, 16'h1, 0, 0, 16'h1, 0));
        vecs.push_back(key(5'h2, 0, S_A, 16'h12, 0, 0, 16'h12, 0));
        vecs.push_back(key(5'hA, 0, S_A, 16'h12A, 0, 0, 16'h12A, 0));
        vecs.push_back(key(5'hF, 0, S_A, 16'h12AF, 0, 0, 16'h12AF, 0));
        vecs.push_back(key(5'h3, 0, S_A, 16'h12AF, 0, 0, 16'h12AF, 0));
        vecs.push_back(key(K_EXE, 0, S_A, 16'h12AF, 0, 0, 16'h12AF, 0));
        vecs.push_back(key(5'h18, 0, S_A, 16'h12AF, 0, 0, 16'h12AF, 0));
        vecs.push_back(key(K_CE, 0, S_A, 0, 0, 0, 0, 0));
        // decimal entry rejects B
        vecs.push_back(key(5'h9, 1, S_A, 16'd9, 0, 0, 16'd9, 0));
        vecs.push_back(key(5'hB, 1, S_A, 16'd9, 0, 0, 16'd9, 0));
        vecs.push_back(key(5'h9, 1, S_A, 16'h63, 0, 0, 16'h63, 0));
        // operator swap, B entry, CE in S_B, EXE with empty B
        vecs.push_back(key(K_ADD, 0, S_B, 16'h63, 0, 0, 16'h63, 0));
        vecs.push_back(key(K_MUL, 0, S_B, 16'h63, 0, 1, 16'h63, 0));
        vecs.push_back(key(5'h7, 0, S_B, 16'h63, 16'h7, 1, 16'h7, 0));
        vecs.push_back(key(K_OR, 0, S_B, 16'h63, 16'h7, 1, 16'h7, 0));
        vecs.push_back(key(K_CE, 0, S_B, 16'h63, 0, 1, 16'h63, 0));
        vecs.push_back(key(K_EXE, 0, S_B, 16'h63, 0, 1, 16'h63, 0));
        vecs.push_back(key(K_CLR, 0, S_A, 0, 0, 0, 0, 0));
        // full operation: 5 + 7, ready held low three cycles
        vecs.push_back(key(5'h5, 0, S_A, 16'h5, 0, 0, 16'h5, 0));
        vecs.push_back(key(K_ADD, 0, S_B, 16'h5, 0, 0, 16'h5, 0));
        vecs.push_back(key(5'h7, 0, S_B, 16'h5, 16'h7, 0, 16'h7, 0));
        vecs.push_back(key(K_EXE, 0, S_WAIT, 16'h5, 16'h7, 0, 16'h7, 1));
        vecs.push_back(idle(0, 0, 0, S_WAIT, 16'h5, 16'h7, 0, 16'h7, 1));
        vecs.push_back(idle(0, 1, 16'd99, S_WAIT, 16'h5, 16'h7, 0, 16'h7, 1));
        vecs.push_back(mk(1, 5'h3, 0, 0, 0, 0, S_WAIT, 16'h5, 16'h7, 0, 16'h7, 1));
        vecs.push_back(idle(1, 0, 0, S_WAIT, 16'h5, 16'h7, 0, 16'h7, 0));
        vecs.push_back(idle(0, 1, 16'd12, S_RES, 16'h5, 16'h7, 0, 16'd12, 0));
        vecs.push_back(key(K_EXE, 0, S_RES, 16'h5, 16'h7, 0, 16'd12, 0));
`ifdef CALC_CHAIN_EN
        vecs.push_back(key(K_SUB, 0, S_B, 16'd12, 0, 4, 16'd12, 0));
        vecs.push_back(key(5'h2, 0, S_B, 16'd12, 16'd2, 4, 16'd2, 0));
        vecs.push_back(key(K_EXE, 0, S_WAIT, 16'd12, 16'd2, 4, 16'd2, 1));
        vecs.push_back(idle(1, 0, 0, S_WAIT, 16'd12, 16'd2, 4, 16'd2, 0));
        vecs.push_back(idle(0, 1, 16'd10, S_RES, 16'd12, 16'd2, 4, 16'd10, 0));
        vecs.push_back(key(5'h8, 0, S_A, 16'h8, 16'd2, 4, 16'h8, 0));
        vecs.push_back(key(K_CE, 0, S_A, 0, 16'd2, 4, 0, 0));
`else
        vecs.push_back(key(K_SUB, 0, S_RES, 16'h5, 16'h7, 0, 16'd12, 0));
        vecs.push_back(key(5'h8, 0, S_A, 16'h8, 16'h7, 0, 16'h8, 0));
        vecs.push_back(key(K_CE, 0, S_A, 0, 16'h7, 0, 0, 0));
`endif
        vecs.push_back(key(K_CLR, 0, S_A, 0, 0, 0, 0, 0));
        // CLR with exe_ready in S_WAIT, later result ignored
        vecs.push_back(key(5'h3, 0, S_A, 16'h3, 0, 0, 16'h3, 0));
        vecs.push_back(key(K_ADD, 0, S_B, 16'h3, 0, 0, 16'h3, 0));
        vecs.push_back(key(5'h4, 0, S_B, 16'h3, 16'h4, 0, 16'h4, 0));
        vecs.push_back(key(K_EXE, 0, S_WAIT, 16'h3, 16'h4, 0, 16'h4, 1));
        vecs.push_back(mk(1, K_CLR, 0, 1, 0, 0, S_A, 0, 0, 0, 0, 0));
        vecs.push_back(idle(0, 1, 16'd77, S_A, 0, 0, 0, 0, 0));
        vecs.push_back(key(5'h6, 0, S_A, 16'h6, 0, 0, 16'h6, 0));

        rst = 1'b1; key_valid = 1'b0; val = 5'h0; dec_mode = 1'b0;
        exe_ready = 1'b0; res_valid = 1'b0; result = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset state", state, S_A);
        chk("reset op_a", op_a, 0);
        chk("reset op_b", op_b, 0);
        chk("reset op_code", op_code, 0);
        chk("reset disp", disp_value, 0);
        chk("reset exe_valid", exe_valid, 0);

        for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

        // synchronous reset mid-entry
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst state", state, S_A);
        chk("midrst op_a", op_a, 0);
        chk("midrst disp", disp_value, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/calc_entry_fsm.md
# calc_entry_fsm

Operand/operator entry sequencer for the grid calculator. It sits directly downstream of the grid cursor. On each select pulse it consumes the cursor's 5-bit `val` code and builds operand A, the operator and operand B, in hex or decimal. On EXE it hands the operation to the ALU over a valid/ready handshake, captures the returned result and exposes the value to display.

## Interface
Parameters:
- `W`, 16: operand/result width in bits.
- `N_DIGITS`, 4: maximum digits per operand.

Ports:
- `clk`  in  1: clock (VGA pixel clock domain).
- `rst`  in  1: reset; synchronous, active-high.
- `key_valid`  in  1: one-cycle select pulse; `val` is sampled on this cycle.
- `val`  in  5: cursor code. 0x00–0x0F digit; 0x10 ADD; 0x11 MUL; 0x12 AND; 0x13 EXE; 0x14 SUB; 0x15 OR; 0x16 CE; 0x17 CLR; others ignored.
- `dec_mode`  in  1: 1 = decimal entry (digits 0xA–0xF rejected), 0 = hex.
- `op_a`, `op_b`  out  W: latched operands.
- `op_code`  out  3: `val[2:0]` of the selected operator (ADD 0, MUL 1, AND 2, SUB 4, OR 5).
- `exe_valid`  out  1: operation request; held until `exe_ready`.
- `exe_ready`  in  1: ALU accepts the request.
- `res_valid`  in  1: one-cycle result strobe from the ALU.
- `result`  in  W: ALU result.
- `disp_value`  out  W: value to render.
- `state`  out  2: current FSM state, for the display overlay.

## Operation
- States:
  - S_A (0): entering A.
  - S_B (1): entering B.
  - S_WAIT (2): request pending.
  - S_RES (3): showing result.
- Digit accumulation:
  - Hex: `x = (x<<4) | d`.
  - Decimal: `x = x*10 + d`, truncated to W bits.
  - Accepted only while the digit count < `N_DIGITS`; extra digits are ignored and the count saturates.
  - Decimal mode rejects `d > 9`.
  - Changing `dec_mode` mid-entry keeps the stored binary value and count.
- S_A:
  - Digit: accumulate into A.
  - Operator: latch `op_code`, clear B and its count, go to S_B.
  - CE: clear A and its count.
  - EXE: ignored.
- S_B:
  - Digit: accumulate into B.
  - Operator: replaces `op_code` only while B count = 0; otherwise ignored.
  - CE: clear B and its count.
  - EXE with B count > 0: raise `exe_valid`, go to S_WAIT. EXE with B count = 0: ignored.
- S_WAIT:
  - `exe_valid` stays high until a cycle with `exe_ready` = 1, then drops.
  - First `res_valid` after the handshake: capture `result` into the result register, go to S_RES.
  - All keys except CLR are ignored.
- S_RES:
  - Digit: A = that digit (count 1), go to S_A.
  - Operator: see Configuration.
  - CE: go to S_A with A = 0.
  - EXE: ignored.
- CLR in any state: A, B, result, counts and `op_code` cleared; `exe_valid` drops; go to S_A.
- `res_valid` outside S_WAIT, or before the handshake completes, is ignored.
- `disp_value`: A in S_A; B in S_B (A if B count = 0); B in S_WAIT; result in S_RES.

## Timing
- Reset values: state S_A; `op_a`, `op_b`, `disp_value`, `op_code` = 0; `exe_valid` = 0.
- All outputs are registered. A key accepted at cycle n is visible at n+1.
- `exe_valid` rises at n+1 after EXE at n.
- Handshake:
  - A transfer occurs on any cycle with `exe_valid && exe_ready`.
  - `exe_valid` is 0 in the following cycle.
  - `op_a`, `op_b` and `op_code` are stable while `exe_valid` = 1.
- A `result` captured at cycle m is shown at m+1.
- Simultaneous `key_valid` (CLR) and `res_valid` in S_WAIT: CLR wins and the result is discarded.
- Simultaneous `key_valid` (CLR) and `exe_ready`: CLR wins; the ALU sees the transfer but its `res_valid` is later ignored.
- `rst` mid-operation: same effect as CLR, plus the reset values above.

## Configuration
- `CALC_CHAIN_EN` defined: an operator in S_RES sets A = result (A count = `N_DIGITS`, so further digits into A are blocked), latches `op_code`, clears B, and goes to S_B.
- Without `CALC_CHAIN_EN`: an operator in S_RES is ignored.

## Structure
- Package `calc_pkg` holds:
  - the `val` code localparams (digits, operators, EXE, CE, CLR);
  - the `op_code` enum;
  - the state enum.
- The sub-module `digit_accum` (value + count registers; clear, digit and mode inputs) is instantiated twice, once for A and once for B.

## Test plan
- Hex entry: keys 1, 2, A, F, 3 → A = 0x12AF; the 5th digit is ignored; `disp_value` = 0x12AF.
- Decimal entry: `dec_mode` = 1, keys 9, B, 9 → A = 99 (0x63); B rejected.
- Full operation: keys 5, ADD, 7, EXE; `exe_ready` held 0 for 3 cycles then 1 → `exe_valid` high for 4 cycles with `op_a` = 5, `op_b` = 7, `op_code` = 0. Then `res_valid` with `result` = 12 → S_RES, `disp_value` = 12.
- Edge keys: EXE with empty B → no `exe_valid`. Operator swap: 3, ADD, MUL → `op_code` = 1. CE in S_B → B = 0 and A unchanged.
- CLR in S_WAIT while `exe_valid` is high → next cycle S_A, all values 0; a later `res_valid` is ignored.
- With `CALC_CHAIN_EN`: result 12, then SUB, 2, EXE → `op_a` = 12, `op_b` = 2, `op_code` = 4. Without the macro the SUB key is ignored.
